lm_sm_sequencer: RTL
====================

// Module: lm_sm_sequencer
// PURPOSE
//  Micro-sequencer for LM/SM (load/store multiple) in the 16-bit pipelined core.
//  Sits in the memory stage, directly upstream of data_memory. Expands one
//  LM/SM into back-to-back single-word accesses: drives address, active-low
//  write strobe and register index. Stalls the upstream pipeline until the
//  register list is exhausted.
// PARAMETERS
//  ADDR_W   16  data-memory address / base-register width
//  NREGS    8   register-list width; bit i selects Ri
//  IDX_W    3   register index width, clog2(NREGS)
// PORTS
//  clk         in   1       clock; all state changes on posedge
//  reset       in   1       synchronous, active-low
//  start       in   1       LM/SM present in stage; sampled only in IDLE
//  is_store    in   1       1 = SM (regs -> mem), 0 = LM (mem -> regs)
//  base_addr   in   ADDR_W  RA value = address of first transfer
//  reg_list    in   NREGS   imm8 register list
//  flush       in   1       squash from branch/jump resolution; aborts op
//  mem_addr    out  ADDR_W  data_memory address (read or write)
//  mem_write_n out  1       data_memory write strobe, active-low
//  reg_idx     out  IDX_W   SM: RF read port index; LM: RF write index
//  rf_we       out  1       LM write-back enable (mem out -> R[reg_idx])
//  stall       out  1       hold PC and IF/ID/ID/EX regs this cycle
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle pulse: op complete, pipeline may advance
//  xfer_cnt    out  4       transfers issued for current op (0..8)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, mask=0, addr=0, xfer_cnt=0;
//   outputs mem_write_n=1, rf_we=0, stall=0, busy=0, done=0, reg_idx=0.
//   Reset mid-op discards the op; no strobe in the cycle after reset.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: stall = start & ~flush (combinational). If start & ~flush at posedge:
//   latch mask<=reg_list, addr<=base_addr, cnt<=0, store flag<=is_store;
//   next = RUN if reg_list!=0, else DONE (empty list: no accesses).
//  RUN: reg_idx = index of lowest set bit of mask (ascending R0..R7).
//   mem_addr = addr. SM: mem_write_n=0. LM: rf_we=1; data_memory read is
//   combinational, so write-back happens in the same cycle.
//   Exactly one transfer per cycle. At posedge: clear that mask bit;
//   addr<=addr+1 (mod 2^ADDR_W, FFFF wraps to 0000); cnt<=cnt+1.
//   Next = DONE when the cleared mask becomes 0. stall=1 throughout RUN.
//  DONE: done=1, stall=0, no strobes; next=IDLE. start is ignored in DONE.
//  Latency: N set bits -> N RUN cycles + 1 DONE cycle after start accepted.
//   Empty list -> DONE in the next cycle.
//  flush: highest priority after reset. In any state it combinationally forces
//   mem_write_n=1, rf_we=0, done=0, stall=0. At posedge -> IDLE, mask cleared.
//   Transfers already done are not undone.
//  Outside RUN: mem_write_n=1, rf_we=0. mem_addr/reg_idx hold last values,
//   with no meaning.
//  Only one of mem_write_n==0 and rf_we==1 is ever active in a cycle.
// TESTING
//  T1 reset=0 for 2 cycles with start=1 -> all outputs at reset values,
//     no strobe.
//  T2 SM base=0x0010, list=8'b0110_0000 -> cycles: (addr 0x0010, idx 5, we_n=0),
//     (0x0011, idx 6, we_n=0), done pulse; stall high 3 cycles; xfer_cnt=2.
//  T3 LM base=0x0000, list=8'hFF -> 8 rf_we cycles, idx 0..7, addr 0..7,
//     then done; mem[i] loaded into Ri.
//  T4 LM list=8'h00 -> one cycle with stall=1, then done; rf_we and
//     mem_write_n never active.
//  T5 SM base=0xFFFF, list=8'b0000_0011 -> addr 0xFFFF (R0), then 0x0000 (R1).
//  T6 SM list=8'h0F, flush asserted in the 2nd RUN cycle -> that cycle
//     we_n=1; only R0 stored; IDLE next; no done pulse. Repeat with reset=0
//     instead of flush -> same abort, reset values.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lm_sm_sequencer_if
//  Purpose  : Bundle of the LM/SM sequencer's pipeline-side request signals
//             and its data-memory / register-file / hazard outputs.
//  Ports    : master - drives start/is_store/base_addr/reg_list/flush,
//                      observes the sequencer outputs
//             slave  - the sequencer itself
//  Revision : 1.0 - initial release
// ============================================================================
interface lm_sm_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8,
    parameter int IDX_W  = 3
);
    logic              start;
    logic              is_store;
    logic [ADDR_W-1:0] base_addr;
    logic [NREGS-1:0]  reg_list;
    logic              flush;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write_n;
    logic [IDX_W-1:0]  reg_idx;
    logic              rf_we;
    logic              stall;
    logic              busy;
    logic              done;
    logic [3:0]        xfer_cnt;

    modport master (
        output start, is_store, base_addr, reg_list, flush,
        input  mem_addr, mem_write_n, reg_idx, rf_we, stall, busy, done, xfer_cnt
    );

    modport slave (
        input  start, is_store, base_addr, reg_list, flush,
        output mem_addr, mem_write_n, reg_idx, rf_we, stall, busy, done, xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lm_sm_sequencer
//  Purpose  : Memory-stage micro-sequencer for LM/SM. Expands one load/store
//             multiple into back-to-back single-word accesses (ascending
//             register order, ascending address) and stalls the upstream
//             pipeline until the register list is exhausted.
//  Ports    : clk    - clock, all state changes on posedge
//             reset  - synchronous, active-low
//             bus    - lm_sm_sequencer_if.slave: start/is_store/base_addr/
//                      reg_list/flush in; mem_addr/mem_write_n/reg_idx/
//                      rf_we/stall/busy/done/xfer_cnt out
//  Revision : 1.0 - initial release
// ============================================================================
module lm_sm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8,
    parameter int IDX_W  = 3
) (
    input  wire logic            clk,
    input  wire logic            reset,
    lm_sm_sequencer_if.slave     bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]        r_state;
    logic [NREGS-1:0]  r_mask;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_cnt;
    logic              r_store;

    logic [IDX_W-1:0]  w_idx;
    logic [NREGS-1:0]  w_mask_next;
    logic              w_live;
    logic              w_idle;
    logic              w_run;
    logic              w_done;

    // Reset and flush both squash every strobe in the cycle they are
    // asserted, so an aborted op never issues a further access.
    assign w_live = reset & ~bus.flush;
    assign w_idle = (r_state == c_st_idle);
    assign w_run  = (r_state == c_st_run);
    assign w_done = (r_state == c_st_done);

    // Lowest set bit of the remaining mask selects the register served now.
    always_comb begin
        w_idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit: x & (x - 1).
    assign w_mask_next = r_mask & (r_mask - NREGS'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_mask  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_store <= 1'b0;
        end else if (bus.flush) begin
            r_state <= c_st_idle;
            r_mask  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_mask  <= bus.reg_list;
                        r_addr  <= bus.base_addr;
                        r_cnt   <= '0;
                        r_store <= bus.is_store;
                        // An empty list performs no accesses at all.
                        r_state <= (bus.reg_list != '0) ? c_st_run : c_st_done;
                    end
                end
                c_st_run: begin
                    r_mask <= w_mask_next;
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt + 4'd1;
                    if (w_mask_next == '0) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.mem_addr    = r_addr;
    assign bus.reg_idx     = w_idx;
    assign bus.mem_write_n = ~(w_live & w_run & r_store);
    // Data memory reads combinationally, so LM write-back is same-cycle.
    assign bus.rf_we       = w_live & w_run & ~r_store;
    assign bus.stall       = w_live & ((w_idle & bus.start) | w_run);
    assign bus.busy        = ~w_idle;
    assign bus.done        = w_live & w_done;
    assign bus.xfer_cnt    = r_cnt;

endmodule
`default_nettype wire
